// File: rtl/arb_mux_reg.sv
// N-channel arbitrated merge onto one registered valid/ready output; 1-cycle latency, full throughput.
// Backpressure: a held beat with out_ready low blocks all in_ready; drain and reload can share an edge.
module arb_mux_reg #(
  parameter int W  = 5,
  parameter int N  = 4,
  parameter int RR = 1,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [SELW-1:0] ptr_q, ptr_d;
  logic [W-1:0]    data_q, data_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            vld_q, vld_d;

  logic [SELW-1:0] start;
  logic [SELW-1:0] grant_idx;
  logic            grant_vld;
  logic [W-1:0]    grant_data;
  logic            free;
  logic            xfer;

  assign start = (RR != 0) ? ptr_q : '0;

  // Search start, start+1, ... modulo N; an extra bit keeps the sum from wrapping early.
  always_comb begin
    logic [SELW:0] sum;
    grant_vld = 1'b0;
    grant_idx = '0;
    sum       = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, start} + (SELW+1)'(k);
      if (sum >= (SELW+1)'(N)) begin
        sum = sum - (SELW+1)'(N);
      end
      if (!grant_vld && in_valid[sum[SELW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = sum[SELW-1:0];
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data = in_data[i*W +: W];
      end
    end
  end

  assign free = !vld_q || out_ready;
  assign xfer = free && grant_vld && rst_n;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer && (grant_idx == SELW'(i));
    end
  end

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    sel_d  = sel_q;
    ptr_d  = ptr_q;
    if (xfer) begin
      vld_d  = 1'b1;
      data_d = grant_data;
      sel_d  = grant_idx;
      if (RR != 0) begin
        ptr_d = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + 1'b1;
      end
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      sel_q  <= '0;
      ptr_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      sel_q  <= sel_d;
      ptr_q  <= ptr_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed bench for arb_mux_reg: one round-robin and one fixed-priority instance,
// each with its own producers, checked against a reference arbiter and a beat scoreboard.
module tb_arb_mux_reg;

  localparam int W = 5;
  localparam int N = 4;

  typedef struct packed {
    logic [1:0] sel;
    logic [4:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    vld  [2];
  logic [N*W-1:0]  dat  [2];
  logic            ordy [2];
  logic [N-1:0]    rdy  [2];
  logic [W-1:0]    odat [2];
  logic [1:0]      osel [2];
  logic            oval [2];

  int              m_ptr  [2];
  logic            m_vld  [2];
  logic [W-1:0]    m_data [2];
  logic [1:0]      m_sel  [2];
  logic            xfer   [2];
  logic [N-1:0]    pend   [2];
  logic [N*W-1:0]  pdat   [2];
  beat_t           sbq0 [$];
  beat_t           sbq1 [$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arb_mux_reg #(.W(W), .N(N), .RR(1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .in_data(dat[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .out_data(odat[0]), .out_sel(osel[0]), .out_valid(oval[0]), .out_ready(ordy[0])
  );

  arb_mux_reg #(.W(W), .N(N), .RR(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .in_data(dat[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .out_data(odat[1]), .out_sel(osel[1]), .out_valid(oval[1]), .out_ready(ordy[1])
  );

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (v[2'(i)]) return i;
    end
    return -1;
  endfunction

  // Inputs are set at posedge+1; checks run at posedge+3 (in_ready) and next posedge+1 (outputs).
  task automatic step();
    int g [2];
    logic [N-1:0] exp_rdy;
    beat_t b;
    #2;
    for (int d = 0; d < 2; d++) begin
      if (rst_n) begin
        for (int i = 0; i < N; i++) begin
          if (pend[d][i]) begin
            chk("stable_vld", d, 32'(vld[d][i]), 32'd1);
            chk("stable_dat", d, 32'(dat[d][i*W +: W]), 32'(pdat[d][i*W +: W]));
          end
        end
      end
      g[d] = model_grant(vld[d], (d == 0) ? m_ptr[d] : 0);
      exp_rdy = '0;
      if (rst_n && (!m_vld[d] || ordy[d]) && g[d] >= 0) exp_rdy[2'(g[d])] = 1'b1;
      chk("in_ready", d, 32'(rdy[d]), 32'(exp_rdy));
      xfer[d] = (exp_rdy != '0);
      if (xfer[d]) begin
        b.sel  = 2'(g[d]);
        b.data = dat[d][g[d]*W +: W];
        if (d == 0) sbq0.push_back(b); else sbq1.push_back(b);
      end
      pend[d] = rst_n ? (vld[d] & ~rdy[d]) : '0;
      pdat[d] = dat[d];
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_vld[d] = 1'b0; m_ptr[d] = 0; m_data[d] = '0; m_sel[d] = '0;
        if (d == 0) sbq0.delete(); else sbq1.delete();
      end else if (xfer[d]) begin
        b = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
        m_vld[d] = 1'b1; m_data[d] = b.data; m_sel[d] = b.sel;
        m_ptr[d] = (g[d] + 1) % N;
      end else if (m_vld[d] && ordy[d]) begin
        m_vld[d] = 1'b0;
      end
      chk("out_valid", d, 32'(oval[d]), 32'(m_vld[d]));
      chk("out_data",  d, 32'(odat[d]), 32'(m_data[d]));
      chk("out_sel",   d, 32'(osel[d]), 32'(m_sel[d]));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_vld[d] = 1'b0; m_data[d] = '0; m_sel[d] = '0;
      xfer[d] = 1'b0; pend[d] = '0; pdat[d] = '0;
    end
    // Reset held with every request up
    rst_n = 1'b0;
    vld[0] = 4'b1111; dat[0] = {5'd13, 5'd12, 5'd11, 5'd10}; ordy[0] = 1'b1;
    vld[1] = 4'b0000; dat[1] = '0; ordy[1] = 1'b1;
    step(); step();
    // Round-robin fairness: 0,1,2,3,0,1 at one beat per cycle
    rst_n = 1'b1;
    repeat (6) step();
    // Backpressure on a ch2 beat, then same-edge drain and load of ch0 across the pointer wrap
    rst_n = 1'b0; vld[0] = 4'b0000; step();
    rst_n = 1'b1; vld[0] = 4'b0100; dat[0][14:10] = 5'h1F; ordy[0] = 1'b0; step();
    vld[0] = 4'b0001; dat[0][4:0] = 5'h07; repeat (5) step();
    ordy[0] = 1'b1; step();
    // Sparse requests: search from 1 reaches ch3 before ch0
    vld[0] = 4'b1001; dat[0][19:15] = 5'h15; step();
    vld[0] = 4'b0001; step();
    // Drain without reload keeps data/sel
    vld[0] = 4'b0000; step(); step();
    // Reset while a beat is stalled
    vld[0] = 4'b0010; dat[0][9:5] = 5'h0A; ordy[0] = 1'b0; step(); step(); step();
    rst_n = 1'b0; vld[0] = 4'b1111; step();
    rst_n = 1'b1; ordy[0] = 1'b1; step(); step();
    rst_n = 1'b0; vld[0] = 4'b0000; step();
    rst_n = 1'b1;
    // Fixed priority: ch1 starves ch3 until it drops
    vld[1] = 4'b1010; dat[1] = {5'h1C, 5'h00, 5'h03, 5'h00}; ordy[1] = 1'b1;
    repeat (4) step();
    vld[1] = 4'b1000; step(); step();
    vld[1] = 4'b0010; ordy[1] = 1'b0; step(); step(); step();
    ordy[1] = 1'b1; step();
    vld[1] = 4'b0000; step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
